// File: rtl/cache_mem_adapter.sv
// Line-transfer engine: turns whole-line fill/writeback requests from cache_control into
// a sequence of single-word req/ack memory transactions and assembles fill data.
module cache_mem_adapter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [ADDR_W-1:0]            line_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] line_wdata,
  output logic [LINE_WORDS*WORD_W-1:0] line_rdata,
  output logic                         ca_resp,
  output logic                         busy,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [WORD_W-1:0]            mem_rdata
);

  localparam int unsigned LineW    = LINE_WORDS * WORD_W;
  localparam int unsigned BeatW    = $clog2(LINE_WORDS);
  localparam int unsigned ByteOffW = $clog2(WORD_W / 8);
  localparam int unsigned OffW     = $clog2(LINE_WORDS * WORD_W / 8);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic               op_q, op_d;  // 1 = writeback, 0 = fill
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LineW-1:0]   wdata_q, wdata_d;
  logic [LineW-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      beat_q  <= '0;
      op_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    op_d    = op_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        // Writeback takes priority; cache_control re-presents the fill after ca_resp.
        if (mem_write || mem_read) begin
          op_d    = mem_write;
          base_d  = {line_addr[ADDR_W-1:OffW], {OffW{1'b0}}};
          wdata_d = line_wdata;
          beat_d  = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (mem_ack) begin
          if (!op_q) rdata_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
          if (beat_q == LastBeat) state_d = StResp;
          else                    beat_d  = beat_q + BeatW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only; mem_ack never reaches mem_req combinationally.
  assign mem_req    = (state_q == StXfer);
  assign mem_we     = mem_req & op_q;
  assign mem_addr   = base_q + (ADDR_W'(beat_q) << ByteOffW);
  assign mem_wdata  = wdata_q[beat_q*WORD_W +: WORD_W];
  assign ca_resp    = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign line_rdata = rdata_q;

endmodule

// File: tb/tb_cache_mem_adapter.sv
// Directed bench for cache_mem_adapter: a scoreboard of expected word beats is filled when a
// line request is driven and drained as the adapter issues/accepts memory transactions.
module tb_cache_mem_adapter;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LW     = 8;
  localparam int LINE_W = LW * WORD_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              ca_resp, busy, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  cache_mem_adapter #(
    .ADDR_W    (ADDR_W),
    .WORD_W    (WORD_W),
    .LINE_WORDS(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .line_addr (line_addr),
    .line_wdata(line_wdata),
    .line_rdata(line_rdata),
    .ca_resp   (ca_resp),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
  } beat_t;

  beat_t             sb[$];
  int                errors = 0;
  int                checks = 0;
  logic [LINE_W-1:0] exp_line = '0;
  logic [LINE_W-1:0] wl;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line request and play memory until ca_resp; starts and ends on a negedge.
  task automatic xfer(input bit wr, input bit rd, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wline, input bit waits, input bit change_src,
                      input int exp_resp, input logic [WORD_W-1:0] rbase);
    int                cyc;
    int                resp_at;
    bit                done;
    beat_t             b;
    logic [ADDR_W-1:0] base;
    base = addr & ~32'h1F;
    for (int i = 0; i < LW; i++) begin
      b.addr  = base + ADDR_W'(4 * i);
      b.we    = wr;
      b.wdata = wline[i*WORD_W +: WORD_W];
      b.rdata = rbase + WORD_W'(i);
      sb.push_back(b);
    end
    mem_write  = wr;
    mem_read   = rd;
    line_addr  = addr;
    line_wdata = wline;
    mem_ack    = 1'b0;
    cyc = 0; resp_at = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (change_src && cyc == 1) line_wdata = ~wline;
      mem_ack = 1'b0;
      if (ca_resp) begin
        resp_at   = cyc;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b1;
      end else if (mem_req) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("mem_addr", mem_addr, sb[0].addr);
          chk("mem_we", mem_we, sb[0].we);
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
          chk("busy_xfer", busy, 1);
          mem_rdata = sb[0].rdata;
          mem_ack   = waits ? (cyc % 2 == 0) : 1'b1;
          if (mem_ack) b = sb.pop_front();
        end
      end else begin
        chk("mem_req_high", mem_req, 1);
      end
    end
    if (!done) chk("resp_timeout", 0, 1);
    chk("resp_cycle", resp_at, exp_resp);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    if (rd && !wr)
      for (int i = 0; i < LW; i++) exp_line[i*WORD_W +: WORD_W] = rbase + WORD_W'(i);
    chk("line_rdata", line_rdata, exp_line);
    @(negedge clk);
    chk("resp_single", ca_resp, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; line_addr = '0; line_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp", ca_resp, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_line", line_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait fill
    xfer(1'b0, 1'b1, 32'h0000_1234, '0, 1'b0, 1'b0, 9, 32'hA0);

    // Writeback with a wait state before every beat
    for (int i = 0; i < LW; i++) wl[i*WORD_W +: WORD_W] = 32'h1000 + WORD_W'(i);
    xfer(1'b1, 1'b0, 32'h0000_4000, wl, 1'b1, 1'b0, 17, 32'h0);

    // Simultaneous read and write: write wins
    for (int i = 0; i < LW; i++) wl[i*WORD_W +: WORD_W] = 32'h2200 + WORD_W'(i);
    xfer(1'b1, 1'b1, 32'h0000_8ABC, wl, 1'b0, 1'b0, 9, 32'h0);

    // Back-to-back writeback then fill in the following IDLE cycle
    for (int i = 0; i < LW; i++) wl[i*WORD_W +: WORD_W] = 32'hBEEF_0000 + WORD_W'(i * 3);
    xfer(1'b1, 1'b0, 32'h0001_0040, wl, 1'b0, 1'b0, 9, 32'h0);
    xfer(1'b0, 1'b1, 32'h0001_0060, '0, 1'b1, 1'b0, 17, 32'h50);

    // Source changes after the request has been accepted
    for (int i = 0; i < LW; i++) wl[i*WORD_W +: WORD_W] = 32'h5A5A_0000 + WORD_W'(i);
    xfer(1'b1, 1'b0, 32'h0002_0000, wl, 1'b0, 1'b1, 9, 32'h0);

    // Reset mid-fill at beat 3
    mem_read = 1'b1; line_addr = 32'h0000_2000; mem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_rdata = 32'h7700 + WORD_W'(c);
    end
    chk("pre_rst_addr", mem_addr, 32'h0000_200C);
    chk("pre_rst_req", mem_req, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_line", line_rdata, 0);
    chk("mid_rst_resp", ca_resp, 0);
    mem_read = 1'b0; mem_ack = 1'b0;
    exp_line = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_resp", ca_resp, 0);
      chk("post_rst_busy", busy, 0);
    end

    // Fill after reset recovery
    xfer(1'b0, 1'b1, 32'h0000_3FFF, '0, 1'b0, 1'b0, 9, 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
